// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-word reads, holds each fetched
// instruction until the downstream stage accepts it, and follows redirects.
module fetch_unit #(
    parameter logic [9:0] RESET_PC = 10'h000,
    localparam int unsigned PC_W   = 10,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              mem_rd,
    output logic [PC_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [PC_W-1:0]   instr_pc,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] redirect_tgt;
    logic            handshake;

    // Read request decodes straight from state so it leaves in the FETCH cycle.
    assign mem_rd       = (state == FETCH) && !halt;
    assign mem_addr     = pc;

    assign pc_inc       = pc + PC_W'(4);
    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign handshake    = (state == VALID) && instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC & ALIGN_MASK;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            // An accepted instruction counts even when a redirect lands with it.
            if (handshake && (fetch_count != '1)) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end

            if (redirect_valid) begin
                pc          <= redirect_tgt;
                instr_valid <= 1'b0;
                state       <= FETCH;
            end else begin
                case (state)
                    FETCH: begin
                        if (!halt) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        instr_out   <= mem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end
                    VALID: begin
                        if (handshake) begin
                            pc          <= pc_inc;
                            instr_valid <= 1'b0;
                            state       <= FETCH;
                        end
                    end
                    default: begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a stream-level model predicts the address
// of the next presented instruction; a negedge monitor compares against it.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [9:0]  instr_pc;
    logic [15:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(10'h000)) dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fetch_count    (fetch_count)
    );

    // Instruction memory: data one cycle after the strobe, noise otherwise.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? mem[mem_addr[9:2]] : $urandom();
    end

    int checks = 0;
    int failures = 0;

    // Reference model: the expected queue holds the pc of the next instruction
    // to be presented; the stream advances by +4 on accept or jumps on redirect.
    logic [9:0]  exp_q[$];
    int unsigned exp_cnt = 0;
    int          accepted = 0;
    bit          armed = 0;
    bit          just_reset = 0;

    bit          p_valid = 0;
    bit          p_rst, p_hs, p_redir;
    logic [9:0]  p_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_model();
        logic [9:0] hpc;
        hpc = '0;
        if (!p_valid) return;
        just_reset = 0;
        if (!p_rst) begin
            exp_q.delete();
            exp_q.push_back(10'h000);
            exp_cnt    = 0;
            armed      = 1;
            just_reset = 1;
        end else begin
            if (p_hs) begin
                if (exp_q.size() > 0) hpc = exp_q.pop_front();
                if (exp_cnt != 32'hFFFF) exp_cnt++;
                accepted++;
            end
            if (p_redir) begin
                exp_q.delete();
                exp_q.push_back(p_tgt & 10'h3FC);
            end else if (p_hs) begin
                exp_q.push_back(hpc + 10'd4);
            end
        end
    endtask

    // Commit the model for the edge just taken, then drive the next cycle.
    task automatic step(input bit r, input bit h, input bit rv, input logic [9:0] rpc, input bit rdy);
        @(posedge clk);
        #1;
        apply_model();
        rst            = r;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        p_valid = 1;
        p_rst   = r;
        p_hs    = r && instr_valid && rdy;
        p_redir = rv;
        p_tgt   = rpc;
    endtask

    task automatic wait_valid(input bit rdy, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 10'h000, rdy);
            if (instr_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_fetch_issue(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 10'h000, 1);
            if (mem_rd) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    // Monitor: registered outputs reflect the last edge, mem_rd the next one.
    int         cyc = 0;
    int         rd_cyc = -100;
    bit         prev_valid = 0;
    logic [9:0] front;
    logic [31:0] exp_word;

    always @(negedge clk) begin
        if (armed) begin
            chk("fetch_count", 32'(fetch_count), exp_cnt);
            if (just_reset) begin
                chk("reset_instr_valid", 32'(instr_valid), 32'd0);
                chk("reset_instr_out", instr_out, 32'd0);
                chk("reset_instr_pc", 32'(instr_pc), 32'd0);
            end
            front = (exp_q.size() > 0) ? exp_q[0] : 10'h000;
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(instr_valid), 32'd0);
                end else begin
                    exp_word = mem[front[9:2]];
                    chk("instr_pc", 32'(instr_pc), 32'(front));
                    chk("instr_out", instr_out, exp_word);
                    if (!prev_valid) chk("fetch_latency", 32'(cyc - rd_cyc), 32'd2);
                end
            end
            if (halt || instr_valid) chk("mem_rd_quiet", 32'(mem_rd), 32'd0);
            if (mem_rd) begin
                if (exp_q.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(front));
                rd_cyc = cyc;
            end
        end
        prev_valid = instr_valid;
        cyc++;
    end

    initial begin
        bit r, h, rv, rdy;
        logic [9:0] rpc;

        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[0] = 32'h00500093;

        // Reset, then free-running fetch with an always-ready consumer.
        step(0, 0, 0, 10'h000, 0);
        step(0, 0, 0, 10'h000, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 10'h000, 1);

        // Consumer stalls for five cycles while an instruction is held.
        wait_valid(0, "stall");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 10'h000, 0);
        step(1, 0, 0, 10'h000, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 10'h000, 1);

        // Redirect while the read is outstanding: returning data is dropped.
        wait_fetch_issue("redir_wait");
        step(1, 0, 1, 10'h123, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 10'h000, 1);

        // Redirect to the last word, then wrap to zero.
        step(1, 0, 1, 10'h3FC, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 10'h000, 1);

        // Halt parked in FETCH, then release and read the same pc.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 10'h000, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 10'h000, 1);

        // Reset while an instruction is being held.
        wait_valid(0, "rst_valid");
        step(0, 0, 0, 10'h000, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 10'h000, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(63) != 0);
            h   = ($urandom_range(3) == 0);
            rv  = ($urandom_range(9) == 0);
            rpc = ($urandom_range(4) == 0) ? 10'h3FC : 10'($urandom());
            rdy = ($urandom_range(1) == 1);
            step(r, h, rv, rpc, rdy);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 10'h000, 1);

        chk("min_accepted", 32'(accepted >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 10'h000, byte address of the first fetch after reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low (rst=0 at a rising clk edge resets the block).
REQ-004 Port: halt  input  1  when 1, no new memory read is issued.
REQ-005 Port: redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 Port: redirect_pc  input  10  redirect target byte address; bits [1:0] ignored (treated as 0).
REQ-007 Port: mem_rd  output  1  instruction memory read strobe.
REQ-008 Port: mem_addr  output  10  instruction byte address, word aligned.
REQ-009 Port: mem_rdata  input  32  read data, valid exactly one cycle after mem_rd=1.
REQ-010 Port: instr_valid  output  1  instr_out/instr_pc hold a valid instruction.
REQ-011 Port: instr_ready  input  1  downstream (instruction register/control) accepts the instruction.
REQ-012 Port: instr_out  output  32  fetched instruction word.
REQ-013 Port: instr_pc  output  10  address instr_out was fetched from.
REQ-014 Port: fetch_count  output  16  number of accepted instructions, saturating.

Function
REQ-015 FSM states SHALL be FETCH, WAIT, VALID; all outputs registered except mem_rd and mem_addr, which decode from state and pc.
REQ-016 FETCH: mem_rd=1, mem_addr=pc when halt=0 -> WAIT next cycle; halt=1 -> mem_rd=0, stay in FETCH.
REQ-017 WAIT: mem_rdata captured into instr_out, pc into instr_pc, instr_valid<=1 -> VALID next cycle.
REQ-018 VALID: instr_valid=1 and instr_out/instr_pc stable until instr_valid&instr_ready at a clk edge.
REQ-019 Handshake in VALID: pc<=pc+4, instr_valid<=0, fetch_count increments, -> FETCH.
REQ-020 Fetch latency: mem_rd in cycle N -> instr_valid=1 in cycle N+2; peak throughput one instruction per 3 cycles.
REQ-021 pc arithmetic SHALL be 10-bit modulo: pc+4 from 10'h3FC wraps to 10'h000.
REQ-022 redirect_valid=1 in any state: pc<={redirect_pc[9:2],2'b00}, instr_valid<=0, -> FETCH; in WAIT the returning mem_rdata is discarded.
REQ-023 Redirect coincident with handshake in VALID: handshake counts (fetch_count increments), pc takes redirect target, not pc+4.
REQ-024 Redirect overrides halt for pc update; no request is issued while halt=1.
REQ-025 halt has no effect in WAIT or VALID; an outstanding read completes and is presented normally.
REQ-026 instr_ready while instr_valid=0 SHALL be ignored.
REQ-027 fetch_count SHALL saturate at 16'hFFFF.

Reset
REQ-028 On rst=0 at a clk edge: state=FETCH, pc=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fetch_count=0; rst overrides redirect, halt and handshake.
REQ-029 Reset in WAIT or VALID SHALL discard the in-flight/held instruction; first request issues the cycle after rst returns to 1.

Verification
REQ-030 Release reset, halt=0, memory returns 32'h00500093 at 0x000, instr_ready=1 -> mem_rd at cycle 0 addr 0x000, instr_valid cycle 2 with instr_out=32'h00500093, instr_pc=0x000, next mem_addr=0x004 at cycle 3, fetch_count=1.
REQ-031 instr_ready=0 for 5 cycles after instr_valid -> instr_out/instr_pc unchanged, no mem_rd; raise ready -> single handshake, fetch_count+1.
REQ-032 redirect_valid=1, redirect_pc=10'h123 during WAIT -> returning data never presented; next mem_addr=0x120; instr_pc=0x120 on next valid.
REQ-033 Redirect to 0x3FC, accept one instruction -> next mem_addr=0x000 (wrap).
REQ-034 halt=1 in FETCH for 4 cycles -> mem_rd=0 throughout; halt=0 -> read at unchanged pc; rst=0 asserted in VALID -> instr_valid=0, pc=RESET_PC, fetch_count=0 next cycle.
